// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - round-robin arbiter sharing one FPU between NUM_REQ requesters
// Optional per-requester issue/stall counters under `FPU_ARB_PERF_EN.
module fpu_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int WIDTH           = 32,
  parameter int NUM_OPERANDS    = 3,
  parameter int CMD_W           = 24,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TAG_W           = $clog2(NUM_REQ)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid_i,
  output logic [NUM_REQ-1:0]                    req_ready_o,
  input  logic [NUM_REQ*NUM_OPERANDS*WIDTH-1:0] req_operands_i,
  input  logic [NUM_REQ*CMD_W-1:0]              req_cmd_i,
  output logic [NUM_REQ-1:0]                    rsp_valid_o,
  input  logic [NUM_REQ-1:0]                    rsp_ready_i,
  output logic [WIDTH-1:0]                      rsp_result_o,
  output logic [4:0]                            rsp_status_o,
  input  logic                                  flush_i,
  output logic [NUM_OPERANDS*WIDTH-1:0]         fpu_operands_o,
  output logic [CMD_W-1:0]                      fpu_cmd_o,
  output logic [TAG_W-1:0]                      fpu_tag_o,
  output logic                                  fpu_in_valid_o,
  input  logic                                  fpu_in_ready_i,
  input  logic [WIDTH-1:0]                      fpu_result_i,
  input  logic [4:0]                            fpu_status_i,
  input  logic [TAG_W-1:0]                      fpu_tag_i,
  input  logic                                  fpu_out_valid_i,
  output logic                                  fpu_out_ready_o,
  output logic                                  fpu_flush_o,
  output logic                                  busy_o
`ifdef FPU_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]                 perf_issue_o,
  output logic [NUM_REQ*32-1:0]                 perf_stall_o
`endif
);

  localparam int OPS_W = NUM_OPERANDS * WIDTH;
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t             r_state, w_state_next;
  logic [TAG_W-1:0]   r_rr_ptr, w_ptr_next;
  logic [3:0]         r_count, w_count_next;
  logic [TAG_W-1:0]   w_grant;
  logic               w_any;
  logic               w_tag_ok;
  logic               w_rsp_ready_sel;
  logic               w_issue;
  logic               w_retire;
  logic               w_dec;

  function automatic logic [TAG_W-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[TAG_W-1:0];
  endfunction

  // Scan downward so the smallest offset from the pointer wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[wrap_idx(int'(r_rr_ptr), k)]) begin
        w_any   = 1'b1;
        w_grant = wrap_idx(int'(r_rr_ptr), k);
      end
    end
  end

  assign fpu_operands_o  = req_operands_i[w_grant*OPS_W +: OPS_W];
  assign fpu_cmd_o       = req_cmd_i[w_grant*CMD_W +: CMD_W];
  assign fpu_tag_o       = w_grant;
  assign rsp_result_o    = fpu_result_i;
  assign rsp_status_o    = fpu_status_i;
  assign w_tag_ok        = int'(fpu_tag_i) < NUM_REQ;
  assign w_rsp_ready_sel = w_tag_ok ? rsp_ready_i[fpu_tag_i] : 1'b1;
  assign busy_o          = !rst && (r_count != 4'd0);

  always_comb begin
    w_state_next    = r_state;
    w_ptr_next      = r_rr_ptr;
    w_count_next    = r_count;
    fpu_in_valid_o  = 1'b0;
    req_ready_o     = '0;
    rsp_valid_o     = '0;
    fpu_out_ready_o = 1'b1;
    fpu_flush_o     = 1'b0;
    w_issue         = 1'b0;
    w_retire        = 1'b0;
    w_dec           = 1'b0;
    if (rst) begin
      fpu_flush_o = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          fpu_out_ready_o = w_rsp_ready_sel;
          for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_o[i] = fpu_out_valid_i && w_tag_ok && (fpu_tag_i == TAG_W'(i));
          end
          w_retire = fpu_out_valid_i && fpu_out_ready_o;
          if (flush_i) begin
            fpu_flush_o  = 1'b1;
            w_count_next = 4'd0;
            w_state_next = ST_FLUSH;
          end else begin
            fpu_in_valid_o = w_any && (r_count < MAX_CNT);
            w_issue        = fpu_in_valid_o && fpu_in_ready_i;
            for (int i = 0; i < NUM_REQ; i++) begin
              req_ready_o[i] = w_issue && (w_grant == TAG_W'(i));
            end
            if (w_issue) w_ptr_next = wrap_idx(int'(w_grant), 1);
            // Never let a stray response wrap the counter below zero.
            w_dec = w_retire && (r_count != 4'd0);
            if (w_issue && !w_dec) w_count_next = r_count + 4'd1;
            else if (!w_issue && w_dec) w_count_next = r_count - 4'd1;
          end
        end
        ST_FLUSH: begin
          w_count_next = 4'd0;
          w_state_next = ST_RUN;
          if (flush_i) begin
            fpu_flush_o  = 1'b1;
            w_state_next = ST_FLUSH;
          end
        end
        default: w_state_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_rr_ptr <= '0;
      r_count  <= 4'd0;
    end else begin
      r_state  <= w_state_next;
      r_rr_ptr <= w_ptr_next;
      r_count  <= w_count_next;
    end
  end

`ifdef FPU_ARB_PERF_EN
  logic [31:0] r_perf_issue [NUM_REQ];
  logic [31:0] r_perf_stall [NUM_REQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        r_perf_issue[i] <= '0;
        r_perf_stall[i] <= '0;
      end else begin
        if (req_ready_o[i] && (r_perf_issue[i] != '1))
          r_perf_issue[i] <= r_perf_issue[i] + 32'd1;
        if (req_valid_i[i] && !req_ready_o[i] && (r_perf_stall[i] != '1))
          r_perf_stall[i] <= r_perf_stall[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    assign perf_issue_o[g*32 +: 32] = r_perf_issue[g];
    assign perf_stall_o[g*32 +: 32] = r_perf_stall[g];
  end
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb/tb_fpu_arbiter.sv - directed vector table plus randomized model comparison for fpu_arbiter
module tb_fpu_arbiter;
  localparam int N    = 4;
  localparam int W    = 32;
  localparam int NO   = 3;
  localparam int CW   = 24;
  localparam int MAXO = 4;
  localparam int TW   = 2;
  localparam int OPW  = NO * W;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*OPW-1:0]  req_operands;
  logic [N*CW-1:0]   req_cmd;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [W-1:0]      rsp_result;
  logic [4:0]        rsp_status;
  logic              flush;
  logic [OPW-1:0]    fpu_operands;
  logic [CW-1:0]     fpu_cmd;
  logic [TW-1:0]     fpu_tag_o;
  logic              fpu_in_valid;
  logic              fpu_in_ready;
  logic [W-1:0]      fpu_result;
  logic [4:0]        fpu_status;
  logic [TW-1:0]     fpu_tag_i;
  logic              fpu_out_valid;
  logic              fpu_out_ready;
  logic              fpu_flush;
  logic              busy;

  fpu_arbiter #(
    .NUM_REQ(N), .WIDTH(W), .NUM_OPERANDS(NO), .CMD_W(CW), .MAX_OUTSTANDING(MAXO), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_operands_i(req_operands), .req_cmd_i(req_cmd),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_status_o(rsp_status),
    .flush_i(flush),
    .fpu_operands_o(fpu_operands), .fpu_cmd_o(fpu_cmd), .fpu_tag_o(fpu_tag_o),
    .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready),
    .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_tag_i(fpu_tag_i),
    .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
    .fpu_flush_o(fpu_flush), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: pointer, in-flight count and a "just flushed" flag.
  int       m_ptr   = 0;
  int       m_count = 0;
  bit       m_fl    = 1'b0;
  logic     e_in_valid, e_out_ready, e_flush, e_busy;
  logic [3:0] e_req_ready, e_rsp_valid;
  int       e_grant;

  function automatic int pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_eval();
    e_grant     = pick(m_ptr, req_valid);
    e_in_valid  = 1'b0;
    e_req_ready = '0;
    e_rsp_valid = '0;
    e_out_ready = 1'b1;
    e_flush     = 1'b1;
    e_busy      = 1'b0;
    if (!rst) begin
      e_busy  = (m_count != 0);
      e_flush = flush;
      if (!m_fl) begin
        e_in_valid  = !flush && (e_grant >= 0) && (m_count < MAXO);
        e_rsp_valid = fpu_out_valid ? (4'b0001 << fpu_tag_i) : 4'b0000;
        e_out_ready = rsp_ready[fpu_tag_i];
      end
      if (e_in_valid && fpu_in_ready) e_req_ready = 4'b0001 << e_grant;
    end
  endtask

  task automatic model_step();
    int iss, ret;
    if (rst) begin
      m_ptr = 0; m_count = 0; m_fl = 1'b0;
    end else if (flush) begin
      m_count = 0; m_fl = 1'b1;
    end else if (m_fl) begin
      m_fl = 1'b0;
    end else begin
      iss = (e_in_valid && fpu_in_ready) ? 1 : 0;
      ret = (fpu_out_valid && e_out_ready) ? 1 : 0;
      m_count = m_count + iss - ret;
      if (iss == 1) m_ptr = (e_grant + 1) % N;
    end
  endtask

  task automatic check_model();
    model_eval();
    chk("in_valid", fpu_in_valid, e_in_valid);
    chk("req_ready", req_ready, e_req_ready);
    chk("rsp_valid", rsp_valid, e_rsp_valid);
    chk("out_ready", fpu_out_ready, e_out_ready);
    chk("fpu_flush", fpu_flush, e_flush);
    chk("busy", busy, e_busy);
    chk("rsp_result", {rsp_status, rsp_result}, {fpu_status, fpu_result});
    if (e_in_valid) begin
      chk("tag", fpu_tag_o, e_grant);
      chk("operands", fpu_operands, req_operands[e_grant*OPW +: OPW]);
      chk("cmd", fpu_cmd, req_cmd[e_grant*CW +: CW]);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic       in_rdy;
    logic       ov;
    logic [1:0] tag;
    logic [3:0] rr;
    logic       fl;
    logic       x_iv;
    logic [3:0] x_rdy;
    logic [1:0] x_tag;
    logic [3:0] x_rv;
    logic       x_ordy;
    logic       x_fl;
    logic       x_busy;
  } vec_t;

  vec_t tbl [14];

  initial begin
    // Directed sequence: reset, round robin, routing back-pressure, limit, flush, reset.
    tbl[0]  = '{1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 4'hF, 1'b0,  1'b0, 4'h0, 2'd0, 4'h0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'hF, 1'b0,  1'b1, 4'h1, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'hF, 1'b0,  1'b1, 4'h2, 2'd1, 4'h0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 4'hF, 1'b1, 1'b1, 2'd2, 4'hF, 1'b0,  1'b1, 4'h4, 2'd2, 4'h4, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 4'hF, 1'b1, 1'b1, 2'd2, 4'hB, 1'b0,  1'b1, 4'h8, 2'd3, 4'h4, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'hF, 1'b0,  1'b1, 4'h1, 2'd0, 4'h0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'hF, 1'b0,  1'b0, 4'h0, 2'd0, 4'h0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 4'hF, 1'b1, 1'b1, 2'd1, 4'hF, 1'b0,  1'b0, 4'h0, 2'd0, 4'h2, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 4'h4, 1'b1, 1'b0, 2'd0, 4'hF, 1'b0,  1'b1, 4'h4, 2'd2, 4'h0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'hF, 1'b1,  1'b0, 4'h0, 2'd0, 4'h0, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 4'hF, 1'b1, 1'b1, 2'd3, 4'h0, 1'b0,  1'b0, 4'h0, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'hF, 1'b0,  1'b1, 4'h8, 2'd3, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 4'hF, 1'b0,  1'b0, 4'h0, 2'd0, 4'h0, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 4'hA, 1'b1, 1'b0, 2'd0, 4'hF, 1'b0,  1'b1, 4'h2, 2'd1, 4'h0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < NO; j++) req_operands[(i*NO + j)*W +: W] = 32'hC0DE_0000 | (i << 8) | j;
      req_cmd[i*CW +: CW] = 24'hC0_0000 | 24'(i);
    end
    rst = 1'b1; req_valid = '0; rsp_ready = '1; flush = 1'b0; fpu_in_ready = 1'b1;
    fpu_out_valid = 1'b0; fpu_tag_i = '0; fpu_result = 32'h3F80_0000; fpu_status = 5'h0;

    for (int t = 0; t < 14; t++) begin
      rst = tbl[t].rst; req_valid = tbl[t].v; fpu_in_ready = tbl[t].in_rdy;
      fpu_out_valid = tbl[t].ov; fpu_tag_i = tbl[t].tag; rsp_ready = tbl[t].rr; flush = tbl[t].fl;
      @(negedge clk);
      chk($sformatf("vec%0d.in_valid", t), fpu_in_valid, tbl[t].x_iv);
      chk($sformatf("vec%0d.req_ready", t), req_ready, tbl[t].x_rdy);
      if (tbl[t].x_iv) chk($sformatf("vec%0d.tag", t), fpu_tag_o, tbl[t].x_tag);
      chk($sformatf("vec%0d.rsp_valid", t), rsp_valid, tbl[t].x_rv);
      chk($sformatf("vec%0d.out_ready", t), fpu_out_ready, tbl[t].x_ordy);
      chk($sformatf("vec%0d.flush", t), fpu_flush, tbl[t].x_fl);
      chk($sformatf("vec%0d.busy", t), busy, tbl[t].x_busy);
      check_model();
      advance();
    end

    // Back-to-back flush: second cycle must re-enter flush with fpu_flush_o high.
    rst = 1'b0; req_valid = 4'hF; fpu_out_valid = 1'b0; flush = 1'b1;
    @(negedge clk); chk("flush2a", fpu_flush, 1'b1); check_model(); advance();
    @(negedge clk); chk("flush2b", fpu_flush, 1'b1); chk("flush2b.in_valid", fpu_in_valid, 1'b0);
    check_model(); advance();
    flush = 1'b0;
    @(negedge clk); chk("flush2c.in_valid", fpu_in_valid, 1'b0); check_model(); advance();
    @(negedge clk); chk("flush2d.in_valid", fpu_in_valid, 1'b1); check_model(); advance();

    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 199) == 0);
      flush         = ($urandom_range(0, 19) == 0);
      req_valid     = 4'($urandom);
      rsp_ready     = 4'($urandom);
      fpu_in_ready  = ($urandom_range(0, 3) != 0);
      fpu_out_valid = (m_count > 0 || m_fl) && ($urandom_range(0, 1) == 1);
      fpu_tag_i     = 2'($urandom);
      fpu_result    = $urandom;
      fpu_status    = 5'($urandom);
      for (int i = 0; i < N * NO; i++) req_operands[i*W +: W] = $urandom;
      for (int i = 0; i < N; i++) req_cmd[i*CW +: CW] = 24'($urandom);
      @(negedge clk);
      check_model();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
